// File: rtl/tone_player_pkg.sv
// tone_player_pkg -- shared definitions for the tone player.
//   state_t        : player FSM states
//   REST           : half-period value that marks a silent note
//   EIGHTH..TWO    : note lengths in eighth-note units
//   NOTE_*         : note half-periods in clk cycles (50 MHz clock)
package tone_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [19:0] REST = 20'd1;

    localparam logic [4:0] EIGHTH        = 5'd1;
    localparam logic [4:0] QUARTER       = 5'd2;
    localparam logic [4:0] QUARTEREIGHTH = 5'd3;
    localparam logic [4:0] HALF          = 5'd4;
    localparam logic [4:0] ONE           = 5'd8;
    localparam logic [4:0] TWO           = 5'd16;

    // Half-periods: 50e6 / (2 * f)
    localparam logic [19:0] NOTE_C4 = 20'd95556;
    localparam logic [19:0] NOTE_D4 = 20'd85131;
    localparam logic [19:0] NOTE_E4 = 20'd75843;
    localparam logic [19:0] NOTE_F4 = 20'd71586;
    localparam logic [19:0] NOTE_G4 = 20'd63776;
    localparam logic [19:0] NOTE_A4 = 20'd56818;
    localparam logic [19:0] NOTE_B4 = 20'd50619;
    localparam logic [19:0] NOTE_C5 = 20'd47778;

endpackage

// File: rtl/tone_player_tone_gen.sv
// tone_gen -- square-wave divider.
//   clk, rst_n   : clock, async active-low reset
//   enable       : run the divider; low clears the count and forces wave=0
//   half_period  : cycles between toggles; 0 or 1 means silence
//   wave         : registered square wave, starts low
module tone_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [19:0] half_period,
    output logic        wave
);

    logic [19:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (!enable || half_period <= 20'd1) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half_period - 20'd1) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

endmodule

// File: rtl/tone_player.sv
// tone_player -- steps through a sheet ROM, playing each note as a square wave.
//   Parameters: EIGHTH_TICKS (clk cycles per eighth), LAST_INDEX (final sheet index)
//   clk, rst_n      : clock, async active-low reset
//   start, stop     : single-cycle play / abort requests
//   note, duration  : current ROM entry (half-period, length in eighths)
//   number          : registered ROM index
//   speaker         : audio output
//   busy, done      : not-IDLE flag, one-cycle song-complete pulse
// Build option: define TONE_PLAYER_LOOP_EN to restart the song at index 0
// after the last entry instead of stopping.
module tone_player
    import tone_player_pkg::*;
#(
    parameter int EIGHTH_TICKS = 3125000,
    parameter int LAST_INDEX   = 44
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [19:0] note,
    input  logic [4:0]  duration,
    output logic [9:0]  number,
    output logic        speaker,
    output logic        busy,
    output logic        done
);

    // 31*EIGHTH_TICKS is never a power of two, so the longest note minus
    // one always fits in DW bits.
    localparam int DW = $clog2(31 * EIGHTH_TICKS);

    state_t        state;
    logic [19:0]   note_q;
    logic [DW-1:0] play_cnt;   // remaining PLAY cycles after the current one
    logic [4:0]    dur_eff;
    logic [DW-1:0] play_len;
    logic          last_play;
    logic          tone_en;

    assign dur_eff   = (duration == 5'd0) ? 5'd1 : duration;
    assign play_len  = DW'(dur_eff) * DW'(EIGHTH_TICKS);
    assign last_play = (state == PLAY) && (play_cnt == '0);
    // Dropping enable on the last PLAY cycle (or on stop) clears the wave at
    // the same edge that leaves PLAY, keeping speaker low outside PLAY.
    assign tone_en   = (state == PLAY) && !last_play && !stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            number   <= '0;
            note_q   <= '0;
            play_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Also covers start+stop together in IDLE.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            number <= '0;
                            state  <= FETCH;
                            busy   <= 1'b1;
                        end
                    end
                    FETCH: begin
                        note_q   <= note;
                        play_cnt <= play_len - DW'(1);
                        state    <= PLAY;
                    end
                    PLAY: begin
                        if (play_cnt != '0) begin
                            play_cnt <= play_cnt - DW'(1);
                        end else if (number == 10'(LAST_INDEX)) begin
                            done <= 1'b1;
`ifdef TONE_PLAYER_LOOP_EN
                            number <= '0;
                            state  <= FETCH;
`else
                            state  <= DONE;
`endif
                        end else begin
                            number <= number + 10'd1;
                            state  <= FETCH;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    tone_gen u_tone_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (tone_en),
        .half_period (note_q),
        .wave        (speaker)
    );

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player -- scoreboard bench for tone_player (EIGHTH_TICKS=4, LAST_INDEX=2).
// Expected per-cycle outputs are queued when a song is launched and compared
// each cycle; entries can also carry the start/stop to drive next.
module tb_tone_player;

    localparam int ET = 4;
    localparam int LI = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] note;
    logic [4:0]  duration;
    logic [9:0]  number;
    logic        speaker, busy, done;

    always #5 clk = ~clk;

    logic [19:0] rom_note [0:3];
    logic [4:0]  rom_dur  [0:3];

    // Combinational sheet ROM; indices past LI return a marker entry.
    always_comb begin
        note     = 20'd7;
        duration = 5'd9;
        if (number <= 10'(LI)) begin
            note     = rom_note[number[1:0]];
            duration = rom_dur[number[1:0]];
        end
    end

    tone_player #(.EIGHTH_TICKS(ET), .LAST_INDEX(LI)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .note     (note),
        .duration (duration),
        .number   (number),
        .speaker  (speaker),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic       busy;
        logic       done;
        logic       spk;
        logic [9:0] num;
        bit         nv;   // compare number
        bit         st;   // drive start for the next cycle
        bit         sp;   // drive stop for the next cycle
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic push(input logic b, input logic d, input logic s,
                        input logic [9:0] n, input bit nv, input bit st, input bit sp);
        exp_t e;
        e.busy = b; e.done = d; e.spk = s; e.num = n; e.nv = nv; e.st = st; e.sp = sp;
        q.push_back(e);
    endtask

    // FETCH cycle then PLAY cycles of entry idx; nplay<0 plays the full note.
    task automatic push_note(input int idx, input int nplay, input bit fetch_done, input int stop_k);
        int len;
        int nt;
        logic s;
        nt  = int'(rom_note[idx]);
        len = ((rom_dur[idx] == 5'd0) ? 1 : int'(rom_dur[idx])) * ET;
        if (nplay >= 0) len = nplay;
        push(1'b1, fetch_done, 1'b0, 10'(idx), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < len; k++) begin
            s = (nt > 1) ? logic'((k / nt) % 2) : 1'b0;
            push(1'b1, 1'b0, s, 10'(idx), 1'b1, 1'b0, k == stop_k);
        end
    endtask

    task automatic push_idle(input int n, input bit nv, input logic [9:0] num);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, num, nv, 1'b0, 1'b0);
    endtask

    task automatic push_song_end();
`ifdef TONE_PLAYER_LOOP_EN
        int len0;
        len0 = ((rom_dur[0] == 5'd0) ? 1 : int'(rom_dur[0])) * ET;
        push_note(0, -1, 1'b1, len0 - 1);
        push_idle(2, 1'b0, 10'd0);
`else
        push(1'b1, 1'b1, 1'b0, 10'(LI), 1'b1, 1'b0, 1'b0);
        push_idle(2, 1'b0, 10'd0);
`endif
    endtask

    task automatic run(input int budget);
        exp_t e;
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(posedge clk);
            @(negedge clk);
            e = q.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("speaker", 32'(speaker), 32'(e.spk));
            if (e.nv) chk("number", 32'(number), 32'(e.num));
            start = e.st;
            stop  = e.sp;
            n++;
        end
        if (q.size() > 0) begin
            chk("timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic load_song_a();
        rom_note[0] = 20'd3; rom_dur[0] = 5'd2;
        rom_note[1] = 20'd2; rom_dur[1] = 5'd3;
        rom_note[2] = 20'd3; rom_dur[2] = 5'd1;
        rom_note[3] = 20'd7; rom_dur[3] = 5'd9;
    endtask

    task automatic load_song_b();
        rom_note[0] = 20'd0; rom_dur[0] = 5'd1;
        rom_note[1] = 20'd5; rom_dur[1] = 5'd2;
        rom_note[2] = 20'd1; rom_dur[2] = 5'd0;
        rom_note[3] = 20'd7; rom_dur[3] = 5'd9;
    endtask

    initial begin
        load_song_a();

        // Reset state, with clock running and start held.
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_speaker", 32'(speaker), 32'd0);
        chk("rst_number", 32'(number), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        // Full song A; a start pulse mid-song must be ignored.
        push_note(0, -1, 1'b0, -1);
        push_note(1, -1, 1'b0, -1);
        push_note(2, -1, 1'b0, -1);
        push_song_end();
        q[4].st = 1'b1;
        start = 1'b1;
        run(300);

        // Stop mid-PLAY at index 1 while speaker is high.
        push_note(0, -1, 1'b0, -1);
        push_note(1, 7, 1'b0, 6);
        push_idle(3, 1'b0, 10'd0);
        start = 1'b1;
        run(100);

        // Start and stop together in IDLE: stop wins.
        push_idle(3, 1'b0, 10'd0);
        start = 1'b1;
        stop  = 1'b1;
        run(10);

        // Song B: note 0, a real tone, rest with duration 0.
        load_song_b();
        push_note(0, -1, 1'b0, -1);
        push_note(1, -1, 1'b0, -1);
        push_note(2, -1, 1'b0, -1);
        push_song_end();
        start = 1'b1;
        run(300);

        // Reset dropped between edges mid-PLAY (index 1, speaker high).
        load_song_a();
        push_note(0, -1, 1'b0, -1);
        push_note(1, 3, 1'b0, -1);
        start = 1'b1;
        run(100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_speaker", 32'(speaker), 32'd0);
        chk("async_number", 32'(number), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(4, 1'b1, 10'd0);
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
